tff_count_ctrl: RTL and testbench
=================================

// Module: tff_count_ctrl
// PURPOSE
//  Sequencer for a bank of toggle flip-flops operated as a programmable mod-N up/down counter.
//  Each cycle it computes the per-bit toggle vector (t_en), starts, stops and loads the count,
//  and flags the terminal count. It sits between control logic and the T-cell bank and owns
//  all count sequencing; the bank itself only toggles.
// PARAMETERS
//  WIDTH   4   counter width in bits, >= 2
// PORTS
//  clk       in   1      rising-edge clock, the only clock
//  rst       in   1      asynchronous active-low reset
//  start     in   1      level; in IDLE, begin counting
//  stop      in   1      level; in RUN, return to IDLE and hold count
//  cont      in   1      1 = wrap and keep running; 0 = one pass then DONE
//  up_dn     in   1      1 = count up, 0 = count down; sampled every RUN cycle
//  load      in   1      synchronous load of load_val, any state
//  load_val  in   WIDTH  value to load
//  modulus   in   WIDTH  count modulus N; 0 means 2^WIDTH
//  count     out  WIDTH  current count (state of the T-cell bank)
//  t_en      out  WIDTH  toggle vector applied to the bank this cycle
//  busy      out  1      state == RUN
//  tc        out  1      terminal count: RUN and count at the wrap value for the current direction
//  done      out  1      one-cycle pulse in DONE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, count=0. Outputs t_en, busy, tc, done all 0 while reset is low.
//  FSM states: IDLE, RUN, DONE. Transitions are evaluated in this priority order:
//   1. load=1 (any state): count <= load_val if load_val < N, else 0; state unchanged;
//      no step is taken this cycle.
//   2. RUN & stop: state -> IDLE; count held; t_en=0.
//   3. IDLE & start: state -> RUN; count is not stepped on this edge.
//   4. RUN otherwise: count steps one value per edge.
//      Up: next = (count==N-1) ? 0 : count+1. Down: next = (count==0) ? N-1 : count-1.
//      On the wrap edge: cont=1 -> stay in RUN; cont=0 -> go to DONE (count still wraps).
//   5. DONE: done=1 for exactly one cycle, then -> IDLE. start is ignored while in DONE.
//  Counter datapath:
//   - The count register is built from WIDTH T cells: cell[i] toggles when t_en[i]=1.
//   - t_en = count ^ next when stepping, else 0 (covers hold, load, IDLE, DONE).
//   - On a load cycle, t_en = count ^ loaded value, so the load is also made through toggles.
//  Arithmetic and width:
//   - N is computed in WIDTH+1 bits. modulus=0 gives N = 2^WIDTH, i.e. natural binary wrap.
//   - modulus=1: count is pinned at 0 and tc=1 on every RUN cycle; with cont=0, DONE follows
//     after one RUN cycle.
//   - modulus changed mid-run with count >= new N: the next step forces count to 0 (up)
//     or N-1 (down), and that edge counts as a wrap.
//  tc is combinational from registered state (count, state) plus up_dn, modulus. No latency
//  from the count value to tc.
//  A direction change (up_dn) takes effect on the next edge; tc follows the new direction.
//  Reset asserted mid-run: immediate IDLE with count=0. No done pulse is generated.
// STRUCTURE
//  Shared package: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2).
//  Sub-module tff_cell (inputs t, clk, rst; output q; async active-low reset to 0):
//   - instantiated WIDTH times via generate.
//   - next-value, terminal-detect and FSM logic stay in this module.
// TESTING (WIDTH=4)
//  1. Reset during count=9 in RUN -> count=0, busy=0, t_en=0 immediately, before the next clk edge.
//  2. modulus=10, up, cont=1, start=1 one cycle -> count 0..9, 0..9. tc=1 when count=9.
//     On the 9->0 edge t_en=4'b1001. busy stays 1.
//  3. modulus=10, down, cont=0, load 3 then start -> count 3,2,1,0,9, then DONE.
//     done=1 for exactly one cycle, then IDLE with count=9.
//  4. modulus=0, up, count=15, cont=1 -> wraps to 0, t_en=4'b1111, tc=1 while count=15.
//  5. load=1 and stop=1 together in RUN with load_val=12, modulus=10 -> count=0 (out of range);
//     state stays RUN. Next cycle stop=1 -> IDLE with count held at 0.
//  6. modulus=1, cont=0, start -> tc=1 for one RUN cycle, count stays 0, then done pulse.

Source files
------------

// File: rtl/tff_count_ctrl_pkg.sv
// Shared encodings for the T-cell counter sequencer.
package tff_count_ctrl_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/tff_count_ctrl_if.sv
// Control/status bundle between the sequencer and its controller; the
// controller is the master, the sequencer the slave.
interface tff_count_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             cont;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_en;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, cont, up_dn, load, load_val, modulus,
    input  count, t_en, busy, tc, done
  );

  modport slave (
    input  start, stop, cont, up_dn, load, load_val, modulus,
    output count, t_en, busy, tc, done
  );
endinterface

// File: rtl/tff_count_ctrl_cell.sv
// Single toggle cell: q flips on each rising edge with t=1; async low reset to 0.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  logic q_q;
  logic q_d;

  always_comb q_d = q_q ^ t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/tff_count_ctrl.sv
// Mod-N up/down sequencer driving a bank of T cells; t_en and tc are same-cycle
// combinational from registered state; no backpressure, one step per edge.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  tff_count_ctrl_if.slave  bus
);
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_en_raw;
  logic [WIDTH-1:0] t_en;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH:0]   n_val;
  logic [WIDTH:0]   n_m1;
  logic [WIDTH:0]   cnt_x;
  logic             at_top;
  logic             at_bot;
  logic             wrap;

  // N lives in WIDTH+1 bits so modulus=0 can mean 2^WIDTH.
  always_comb begin
    n_val = {1'b0, bus.modulus};
    if (bus.modulus == '0) n_val = {1'b1, {WIDTH{1'b0}}};
    n_m1  = n_val - (WIDTH+1)'(1);
    cnt_x = {1'b0, count};
  end

  // Out-of-range counts (after a modulus shrink) are treated as a wrap.
  always_comb begin
    at_top   = (cnt_x >= n_m1);
    at_bot   = (count == '0) || (cnt_x >= n_val);
    wrap     = bus.up_dn ? at_top : at_bot;
    step_val = '0;
    if (bus.up_dn) step_val = at_top ? '0 : count + WIDTH'(1);
    else           step_val = at_bot ? n_m1[WIDTH-1:0] : count - WIDTH'(1);
    load_tgt = ({1'b0, bus.load_val} < n_val) ? bus.load_val : '0;
  end

  always_comb begin
    state_d  = state_q;
    t_en_raw = '0;
    if (bus.load) begin
      t_en_raw = count ^ load_tgt;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_RUN;
        S_RUN: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else begin
            t_en_raw = count ^ step_val;
            if (wrap && !bus.cont) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Keep the toggle vector quiet for the whole time reset is held.
  assign t_en = rst ? t_en_raw : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_en[i]),
      .q   (count[i])
    );
  end

  assign bus.count = count;
  assign bus.t_en  = t_en;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.tc    = (state_q == S_RUN) && wrap;
  assign bus.done  = (state_q == S_DONE);
endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl at WIDTH=4 with hand-computed expectations.
module tb_tff_count_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  tff_count_ctrl_if #(.WIDTH(4)) bus ();

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq3[4];
    seq3 = '{3, 2, 1, 0};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.start = 0; bus.stop = 0; bus.cont = 0; bus.up_dn = 1; bus.load = 0;
    bus.load_val = '0; bus.modulus = 4'd10;
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_busy",  bus.busy,  0);
    chk("rst_t_en",  bus.t_en,  0);
    chk("rst_tc",    bus.tc,    0);
    chk("rst_done",  bus.done,  0);
    @(negedge clk);
    rst = 1'b1;

    // mod-10 up, continuous
    bus.cont = 1; bus.up_dn = 1; bus.start = 1;
    tick();
    bus.start = 0;
    chk("start_no_step", bus.count, 0);
    for (int i = 0; i < 20; i++) begin
      chk("up10_count", bus.count, i % 10);
      chk("up10_tc",    bus.tc,    (i % 10) == 9);
      chk("up10_busy",  bus.busy,  1);
      if ((i % 10) == 9) chk("up10_wrap_t_en", bus.t_en, 4'b1001);
      tick();
    end
    repeat (9) tick();
    chk("pre_rst_count", bus.count, 9);

    // async reset mid-run, checked before the next edge
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", bus.count, 0);
    chk("midrst_busy",  bus.busy,  0);
    chk("midrst_t_en",  bus.t_en,  0);
    chk("midrst_done",  bus.done,  0);
    @(negedge clk);
    rst = 1'b1;

    // mod-10 down, one pass
    bus.cont = 0; bus.up_dn = 0; bus.load = 1; bus.load_val = 4'd3;
    #1;
    chk("load3_t_en", bus.t_en, 4'd3);
    tick();
    bus.load = 0;
    chk("load3_count", bus.count, 3);
    chk("load3_idle",  bus.busy,  0);
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("dn10_count", bus.count, seq3[i]);
      chk("dn10_tc",    bus.tc,    i == 3);
      chk("dn10_busy",  bus.busy,  1);
      if (i == 3) chk("dn10_wrap_t_en", bus.t_en, 4'd9);
      tick();
    end
    chk("dn10_done",       bus.done,  1);
    chk("dn10_done_count", bus.count, 9);
    chk("dn10_done_busy",  bus.busy,  0);
    tick();
    chk("dn10_post_done",  bus.done,  0);
    chk("dn10_post_count", bus.count, 9);
    chk("dn10_post_busy",  bus.busy,  0);

    // modulus 0: natural binary wrap
    bus.modulus = 4'd0; bus.up_dn = 1; bus.cont = 1;
    bus.load = 1; bus.load_val = 4'd14;
    tick();
    bus.load = 0; bus.start = 1;
    tick();
    bus.start = 0;
    chk("m0_14_count", bus.count, 14);
    chk("m0_14_tc",    bus.tc,    0);
    tick();
    chk("m0_15_count", bus.count, 15);
    chk("m0_15_tc",    bus.tc,    1);
    chk("m0_15_t_en",  bus.t_en,  4'b1111);
    tick();
    chk("m0_wrap_count", bus.count, 0);
    chk("m0_wrap_busy",  bus.busy,  1);

    // load out of range together with stop: load wins, state stays RUN
    bus.modulus = 4'd10;
    tick();
    chk("ls_pre_count", bus.count, 1);
    bus.load = 1; bus.load_val = 4'd12; bus.stop = 1;
    #1;
    chk("ls_t_en", bus.t_en, 4'd1);
    tick();
    bus.load = 0;
    chk("ls_count", bus.count, 0);
    chk("ls_busy",  bus.busy,  1);
    chk("stop_t_en", bus.t_en, 0);
    tick();
    bus.stop = 0;
    chk("stop_busy",  bus.busy,  0);
    chk("stop_count", bus.count, 0);
    tick();
    chk("stop_hold_count", bus.count, 0);

    // modulus shrink mid-run: out-of-range count forced to 0 going up
    bus.modulus = 4'd0; bus.load = 1; bus.load_val = 4'd13;
    tick();
    bus.load = 0; bus.start = 1;
    tick();
    bus.start = 0;
    bus.modulus = 4'd10;
    #1;
    chk("shrink_t_en", bus.t_en, 4'd13);
    tick();
    chk("shrink_count", bus.count, 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;

    // modulus 1, single pass
    bus.modulus = 4'd1; bus.cont = 0; bus.up_dn = 1; bus.start = 1;
    tick();
    bus.start = 0;
    chk("m1_busy",  bus.busy,  1);
    chk("m1_tc",    bus.tc,    1);
    chk("m1_count", bus.count, 0);
    chk("m1_t_en",  bus.t_en,  0);
    tick();
    chk("m1_done",       bus.done,  1);
    chk("m1_done_count", bus.count, 0);
    chk("m1_done_tc",    bus.tc,    0);
    tick();
    chk("m1_post_done", bus.done, 0);
    chk("m1_post_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
